// File: rtl/csr_file.sv
// Machine-mode CSR file and interrupt/trap sequencer for the MW stage.
// It holds mstatus, mie, mtvec, mepc, mcause and mip. The redirect
// FSM produces the epc target and the one-cycle epc_taken strobe.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | normal operation; mret or a pending enabled interrupt redirects
// REDIR | epc_taken asserted for one cycle; mret/interrupts ignored
module csr_file #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] wdata,
    input  logic            csr_reg_wrMW,
    input  logic            csr_reg_rdMW,
    input  logic            is_mret,
    input  logic            timer_intr,
    input  logic            ext_intr,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] epc,
    output logic            epc_taken
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] REDIR = 1'b1;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;

    logic [0:0]      state;
    logic            st_mie, st_mpie;
    logic            en_mtie, en_meie;
    logic            mtip, meip;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-3:0] mepc;
    logic [XLEN-1:0] mcause;

    logic [11:0]     addr;
    logic            ext_take, tmr_take, take, do_mret;
    logic [3:0]      code;
    logic [XLEN-1:0] tvec_base, trap_target;
    logic            unused_bits;

    assign addr        = inst[31:20];
    assign unused_bits = ^{inst[19:0], pc[1:0]};

    // Trap decision from pre-write CSR state; mret has priority over interrupts.
    always_comb begin
        ext_take    = st_mie & en_meie & meip;
        tmr_take    = st_mie & en_mtie & mtip;
        do_mret     = (state == IDLE) & is_mret;
        take        = (state == IDLE) & ~is_mret & (ext_take | tmr_take);
        code        = ext_take ? 4'd11 : 4'd7;
        tvec_base   = {mtvec[XLEN-1:2], 2'b00};
        trap_target = tvec_base;
        if (mtvec[1:0] == 2'b01)
            trap_target = tvec_base + {{(XLEN-6){1'b0}}, code, 2'b00};
    end

    // Combinational read mux; returns old values during a CSRRW.
    always_comb begin
        rdata = '0;
        if (csr_reg_rdMW | csr_reg_wrMW) begin
            case (addr)
                A_MSTATUS: rdata = {{(XLEN-8){1'b0}}, st_mpie, 3'b000, st_mie, 3'b000};
                A_MIE:     rdata = {{(XLEN-12){1'b0}}, en_meie, 3'b000, en_mtie, 7'b0};
                A_MTVEC:   rdata = mtvec;
                A_MEPC:    rdata = {mepc, 2'b00};
                A_MCAUSE:  rdata = mcause;
                A_MIP:     rdata = {{(XLEN-12){1'b0}}, meip, 3'b000, mtip, 7'b0};
                default:   rdata = '0;
            endcase
        end
    end

    // CSR storage: software writes first, trap/mret updates override them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            en_mtie <= 1'b0;
            en_meie <= 1'b0;
            mtip    <= 1'b0;
            meip    <= 1'b0;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else begin
            mtip <= timer_intr;
            meip <= ext_intr;
            if (csr_reg_wrMW) begin
                case (addr)
                    A_MSTATUS: begin
                        st_mie  <= wdata[3];
                        st_mpie <= wdata[7];
                    end
                    A_MIE: begin
                        en_mtie <= wdata[7];
                        en_meie <= wdata[11];
                    end
                    A_MTVEC:  mtvec  <= wdata;
                    A_MEPC:   mepc   <= wdata[XLEN-1:2];
                    A_MCAUSE: mcause <= wdata;
                    default:  ;
                endcase
            end
            if (take) begin
                mcause  <= {1'b1, {(XLEN-5){1'b0}}, code};
                mepc    <= pc[XLEN-1:2];
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end else if (do_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
        end
    end

    // Redirect FSM and target register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            epc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_mret) begin
                        epc   <= {mepc, 2'b00};
                        state <= REDIR;
                    end else if (take) begin
                        epc   <= trap_target;
                        state <= REDIR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign epc_taken = (state == REDIR);

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file and interrupt/trap sequencer for the 3-stage RV32I core, sitting in the memory/writeback (MW) stage directly downstream of the instruction decoder. It consumes the decoder's `csr_reg_wrMW`, `csr_reg_rdMW` and `is_mret` strobes, once they are pipelined into MW, together with the MW instruction word. It returns CSR read data to the writeback mux (`wb_sel = 2'b11`), and it gives the PC logic a redirect target (`epc`) plus a one-cycle redirect strobe (`epc_taken`) for interrupt entry and `mret`.

## Interface
Parameters:
- `XLEN`, 32: data and address width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-low.
- `inst`, in, 32: MW-stage instruction; the CSR address is `inst[31:20]`.
- `pc`, in, 32: PC of the oldest uncommitted instruction; this is the value saved to `mepc` on interrupt.
- `wdata`, in, 32: rs1 value to write.
- `csr_reg_wrMW`, in, 1: CSR write strobe (CSRRW).
- `csr_reg_rdMW`, in, 1: CSR read strobe.
- `is_mret`, in, 1: MW instruction is `mret`.
- `timer_intr`, in, 1: level-sensitive timer interrupt request.
- `ext_intr`, in, 1: level-sensitive external interrupt request.
- `rdata`, out, 32: CSR read data (combinational).
- `epc`, out, 32: redirect target (registered).
- `epc_taken`, out, 1: redirect strobe, one-cycle pulse (registered).

## Operation
Implemented CSRs (all other addresses read 0 and writes to them are ignored):
- `mstatus` (0x300): only bit 3 (MIE) and bit 7 (MPIE) are storage; all other bits read 0.
- `mie` (0x304): only bit 7 (MTIE) and bit 11 (MEIE) are storage.
- `mtvec` (0x305): full 32 bits. `[1:0]` is the mode (0 = direct, 1 = vectored; values 2 and 3 behave as direct).
- `mepc` (0x341): full 32 bits. Bits `[1:0]` always read 0.
- `mcause` (0x342): full 32 bits.
- `mip` (0x344): read-only. Bit 7 (MTIP) and bit 11 (MEIP) are one-flop registered copies of `timer_intr` and `ext_intr`. Writes are ignored.

Read:
- `rdata` = CSR[`inst[31:20]`] whenever `csr_reg_rdMW | csr_reg_wrMW`; otherwise `rdata` = 0.
- Reads return pre-write (old) values, as CSRRW semantics require.

Write:
- When `csr_reg_wrMW` = 1, the addressed CSR takes `wdata`, masked to its storage bits, at the next edge.

FSM states: IDLE, REDIR.
- IDLE → REDIR on `is_mret`:
  - `epc` <= `mepc`
  - MIE <= MPIE
  - MPIE <= 1
- IDLE → REDIR on a take condition, if no `is_mret` is present. The take condition is MIE & ((MEIE & MEIP) | (MTIE & MTIP)). External has priority over timer. On this transition:
  - `mcause` <= {1'b1, 27'b0, code}, where code = 11 (external) or 7 (timer).
  - `mepc` <= {`pc[31:2]`, 2'b00}.
  - MPIE <= MIE.
  - MIE <= 0.
  - `epc` <= {`mtvec[31:2]`, 2'b00} in direct mode, or that base + 4×code in vectored mode (base+44 for external, base+28 for timer). The addition is 32-bit and wraps modulo 2^32.
- REDIR → IDLE unconditionally.
  - `epc_taken` = 1 exactly while in REDIR.
  - `epc_taken` = 0 in IDLE.
  - `epc` holds its value.
- In REDIR, `is_mret` and take conditions are ignored. The PC logic flushes the MW stage on `epc_taken`.

Simultaneous events:
- `mret` and a pending interrupt in the same cycle: `mret` wins. The interrupt stays pending (level input) and is evaluated again once the FSM is back in IDLE.
- CSR write and trap entry in the same cycle: the take condition uses pre-write values. For `mstatus`/`mepc`/`mcause`, the trap update overrides the CSR write. Writes to other CSRs complete normally.
- CSR write and `mret` in the same cycle: the `mret` update of `mstatus` overrides the write. `epc` uses the pre-write `mepc`.

## Timing
- Reset (`rst` low, asynchronous): all CSRs = 0, the `mip` flops = 0, FSM = IDLE, `epc` = 0, `epc_taken` = 0. Reset mid-REDIR aborts the redirect immediately.
- `rdata` has zero-cycle latency.
- A CSR write is visible to a read in the following cycle.
- Interrupt request to `epc_taken` takes 2 cycles: one cycle for the `mip` sync flop, then one cycle for the IDLE→REDIR edge.
- `is_mret` to `epc_taken` takes 1 cycle.
- `epc_taken` is never high for two consecutive cycles.

## Test plan
- Reset, then read each CSR address and an unimplemented address (0x7C0) → `rdata` = 0 for all; `epc_taken` = 0.
- CSRRW 0x305 with `wdata` = 0x0000_1001, then read 0x305 → 0x0000_1001. Write 0x300 with 0xFFFF_FFFF, then read 0x300 → 0x0000_0088. Write 0x344 with 0xFFFF_FFFF → still reads 0.
- Set `mtvec` = 0x1000, MIE = 1, MTIE = 1, `pc` = 0x204; raise `timer_intr` → 2 cycles later, a one-cycle `epc_taken` with `epc` = 0x1000, `mcause` = 0x8000_0007, `mepc` = 0x204, `mstatus` = 0x80.
- Same setup with `mtvec` = 0x1001, MEIE = 1, and both interrupts raised together → `epc` = 0x102C, `mcause` = 0x8000_000B.
- After the trap, `mret` with `timer_intr` still high → `epc_taken` pulse with `epc` = 0x204 and `mstatus` = 0x88. The interrupt is re-taken on the cycle after REDIR exits.
- Pulse `rst` low while in REDIR → `epc_taken` drops immediately; all CSRs read 0 afterwards.
